// File: rtl/pll_sup_pkg.sv
// Shared state encoding and width helpers for the PLL lock supervisor.
package pll_sup_pkg;

   typedef enum logic [2:0] {
      PLLRST   = 3'd0,
      WAITLOCK = 3'd1,
      STABLE   = 3'd2,
      RELEASE  = 3'd3,
      RUN      = 3'd4,
      FAULT    = 3'd5
   } pll_state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Bits needed to hold 0..max_val, never less than one bit.
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff (
   input  logic clk,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      meta_q <= meta_d;
      sync_q <= sync_d;
   end

   assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: qualifies lock, retries with timeout, then
// releases downstream domain resets one after another.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int NUM_RST        = 3,
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int LOCK_STABLE    = 1024,
   parameter int RST_STAGGER    = 64,
   parameter int MAX_RETRY      = 4
) (
   input  logic                             clkin,
   input  logic                             reset,
   input  logic                             lock,
   input  logic                             relock_req,
   output logic                             pll_reset,
   output logic [NUM_RST-1:0]               rst_out,
   output logic                             locked,
   output logic                             fault,
   output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt,
   output logic [2:0]                       state_o
);

   localparam int REL_LAST = RST_STAGGER * (NUM_RST - 1);
   localparam int CNT_W    = cnt_width(max3(PLL_RST_CYCLES, LOCK_STABLE, REL_LAST));
   localparam int TMO_W    = cnt_width(LOCK_TIMEOUT);
   localparam int RTY_W    = $clog2(MAX_RETRY + 1);

   pll_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [RTY_W-1:0]   retry_q, retry_d;
   logic               pll_reset_q, pll_reset_d;
   logic [NUM_RST-1:0] rst_out_q, rst_out_d;
   logic               locked_q, locked_d;
   logic               fault_q, fault_d;

   logic lock_s;
   logic waiting_now;
   logic timeout;
   logic restart;

   sync_2ff u_lock_sync (
      .clk (clkin),
      .d   (lock),
      .q   (lock_s)
   );

   always_comb begin
      state_d     = state_q;
      retry_d     = retry_q;
      waiting_now = (state_q == WAITLOCK) || (state_q == STABLE);
      timeout     = waiting_now && (tmo_q == TMO_W'(LOCK_TIMEOUT - 1));

      case (state_q)
         PLLRST: begin
            if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) state_d = WAITLOCK;
         end
         WAITLOCK, STABLE: begin
            // Timeout wins over any lock activity in the same cycle.
            if (timeout) begin
               retry_d = (retry_q == RTY_W'(MAX_RETRY)) ? retry_q : retry_q + RTY_W'(1);
               state_d = (retry_d == RTY_W'(MAX_RETRY)) ? FAULT : PLLRST;
            end else if (!lock_s) begin
               state_d = WAITLOCK;
            end else if (state_q == WAITLOCK) begin
               state_d = STABLE;
            end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (!lock_s) begin
               state_d = PLLRST;
            end else if (cnt_q == CNT_W'(REL_LAST)) begin
               state_d = RUN;
               retry_d = '0;
            end
         end
         RUN: begin
            if (!lock_s) state_d = PLLRST;
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = PLLRST;
         end
      endcase

      if (relock_req) begin
         state_d = PLLRST;
         retry_d = '0;
      end

      // Phase counter restarts on every state change; timeout spans WAITLOCK and STABLE.
      restart = relock_req || (state_d != state_q);
      cnt_d   = restart ? '0 : ((cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1));
      if (waiting_now && ((state_d == WAITLOCK) || (state_d == STABLE)))
         tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);
      else
         tmo_d = '0;

      pll_reset_d = (state_d == PLLRST) || (state_d == FAULT);
      fault_d     = (state_d == FAULT);
      locked_d    = (state_d == RUN);
      rst_out_d   = '1;
      if (state_d == RUN) begin
         rst_out_d = '0;
      end else if (state_d == RELEASE) begin
         for (int i = 0; i < NUM_RST; i++)
            rst_out_d[i] = (int'(cnt_d) < RST_STAGGER * i);
      end
   end

   always_ff @(posedge clkin) begin
      if (reset) begin
         state_q     <= PLLRST;
         cnt_q       <= '0;
         tmo_q       <= '0;
         retry_q     <= '0;
         pll_reset_q <= 1'b1;
         rst_out_q   <= '1;
         locked_q    <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         retry_q     <= retry_d;
         pll_reset_q <= pll_reset_d;
         rst_out_q   <= rst_out_d;
         locked_q    <= locked_d;
         fault_q     <= fault_d;
      end
   end

   assign pll_reset = pll_reset_q;
   assign rst_out   = rst_out_q;
   assign locked    = locked_q;
   assign fault     = fault_q;
   assign retry_cnt = retry_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus random lock traffic,
// every cycle compared against a phase/elapsed-time reference model.
module tb_pll_lock_supervisor;

   localparam int NUM_RST        = 3;
   localparam int PLL_RST_CYCLES = 4;
   localparam int LOCK_TIMEOUT   = 100;
   localparam int LOCK_STABLE    = 10;
   localparam int RST_STAGGER    = 5;
   localparam int MAX_RETRY      = 2;
   localparam int RTY_W          = $clog2(MAX_RETRY + 1);

   localparam int S_PLLRST   = 0;
   localparam int S_WAITLOCK = 1;
   localparam int S_STABLE   = 2;
   localparam int S_RELEASE  = 3;
   localparam int S_RUN      = 4;
   localparam int S_FAULT    = 5;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               lock = 1'b0;
   logic               relock_req = 1'b0;
   logic               pll_reset;
   logic [NUM_RST-1:0] rst_out;
   logic               locked;
   logic               fault;
   logic [RTY_W-1:0]   retry_cnt;
   logic [2:0]         state_o;
   logic [10:0]        dut_vec;

   always #5 clk = ~clk;

   pll_lock_supervisor #(
      .NUM_RST        (NUM_RST),
      .PLL_RST_CYCLES (PLL_RST_CYCLES),
      .LOCK_TIMEOUT   (LOCK_TIMEOUT),
      .LOCK_STABLE    (LOCK_STABLE),
      .RST_STAGGER    (RST_STAGGER),
      .MAX_RETRY      (MAX_RETRY)
   ) dut (
      .clkin      (clk),
      .reset      (reset),
      .lock       (lock),
      .relock_req (relock_req),
      .pll_reset  (pll_reset),
      .rst_out    (rst_out),
      .locked     (locked),
      .fault      (fault),
      .retry_cnt  (retry_cnt),
      .state_o    (state_o)
   );

   assign dut_vec = {state_o, pll_reset, rst_out, locked, fault, retry_cnt};

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: current phase, cycles spent in it, cycles since the
   // lock wait began, and failed attempts. Lock seen by the FSM is the raw
   // lock from two edges earlier.
   int m_phase = S_PLLRST;
   int m_age   = 0;
   int m_tmo   = 0;
   int m_retry = 0;
   bit lock_hist[$] = '{1'b0, 1'b0};

   function automatic void model_step(input bit rs, input bit rq, input bit lk);
      bit ls;
      lock_hist.push_front(lk);
      ls = lock_hist[2];
      if (lock_hist.size() > 3) lock_hist.delete(3);
      if (rs) begin
         m_phase = S_PLLRST; m_age = 0; m_tmo = 0; m_retry = 0;
      end else if (rq) begin
         m_phase = S_PLLRST; m_age = 0; m_retry = 0;
      end else begin
         case (m_phase)
            S_PLLRST: begin
               m_age++;
               if (m_age == PLL_RST_CYCLES) begin
                  m_phase = S_WAITLOCK; m_age = 0; m_tmo = 0;
               end
            end
            S_WAITLOCK, S_STABLE: begin
               m_tmo++;
               if (m_tmo == LOCK_TIMEOUT) begin
                  m_retry++;
                  m_phase = (m_retry == MAX_RETRY) ? S_FAULT : S_PLLRST;
                  m_age   = 0;
               end else if (!ls) begin
                  m_phase = S_WAITLOCK;
               end else if (m_phase == S_WAITLOCK) begin
                  m_phase = S_STABLE; m_age = 0;
               end else begin
                  m_age++;
                  if (m_age == LOCK_STABLE) begin
                     m_phase = S_RELEASE; m_age = 0;
                  end
               end
            end
            S_RELEASE: begin
               if (!ls) begin
                  m_phase = S_PLLRST; m_age = 0;
               end else if (m_age == RST_STAGGER * (NUM_RST - 1)) begin
                  m_phase = S_RUN; m_retry = 0;
               end else begin
                  m_age++;
               end
            end
            S_RUN: begin
               if (!ls) begin
                  m_phase = S_PLLRST; m_age = 0;
               end
            end
            default: ;
         endcase
      end
   endfunction

   function automatic logic [10:0] exp_vec();
      logic [2:0] rst;
      int n;
      rst = 3'b111;
      if (m_phase == S_RUN) begin
         rst = 3'b000;
      end else if (m_phase == S_RELEASE) begin
         n = m_age / RST_STAGGER + 1;
         if (n > NUM_RST) n = NUM_RST;
         rst = rst << n;
      end
      return {3'(m_phase), (m_phase == S_PLLRST) || (m_phase == S_FAULT), rst,
              m_phase == S_RUN, m_phase == S_FAULT, 2'(m_retry)};
   endfunction

   task automatic cycle(input bit lk, input bit rq, input bit rs);
      lock       = lk;
      relock_req = rq;
      reset      = rs;
      @(posedge clk);
      model_step(rs, rq, lk);
      #1;
      check_val("lockstep", 32'(dut_vec), 32'(exp_vec()));
      @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check_val({tag, "_state"}, 32'(state_o), S_PLLRST);
      check_val({tag, "_pll_reset"}, 32'(pll_reset), 1);
      check_val({tag, "_rst_out"}, 32'(rst_out), 3'b111);
      check_val({tag, "_locked"}, 32'(locked), 0);
      check_val({tag, "_fault"}, 32'(fault), 0);
      check_val({tag, "_retry"}, 32'(retry_cnt), 0);
   endtask

   task automatic wait_locked(input string tag);
      for (int i = 0; i < 300 && !locked; i++) cycle(1'b1, 1'b0, 1'b0);
      check_val(tag, 32'(locked), 1);
      check_val({tag, "_retry"}, 32'(retry_cnt), 0);
   endtask

   initial begin
      int pr_cnt, t6, t4, t0, tl, lat, bad, trel, tcy, run_left;
      bit lv, rq, rs;

      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
      check_reset_values("reset");

      // Bring-up: lock rises 20 cycles after reset release.
      pr_cnt = int'(pll_reset);
      t6 = -1; t4 = -1; t0 = -1; tl = -1;
      for (int i = 0; i < 300 && !locked; i++) begin
         cycle(i >= 20, 1'b0, 1'b0);
         if (pll_reset) pr_cnt++;
         if (rst_out == 3'b110 && t6 < 0) t6 = i;
         if (rst_out == 3'b100 && t4 < 0) t4 = i;
         if (rst_out == 3'b000 && t0 < 0) t0 = i;
         if (locked && tl < 0) tl = i;
      end
      check_val("bringup_pll_reset_len", pr_cnt, PLL_RST_CYCLES);
      check_val("bringup_stagger_1", t4 - t6, RST_STAGGER);
      check_val("bringup_stagger_2", t0 - t4, RST_STAGGER);
      check_val("bringup_locked_delay", tl - t0, 1);
      check_val("bringup_locked", 32'(locked), 1);
      check_val("bringup_retry", 32'(retry_cnt), 0);

      // Lock lost while running.
      lat = -1;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'b0, 1'b0);
         if (lat < 0 && rst_out == 3'b111 && !locked && pll_reset) lat = i + 1;
      end
      check_val("loss_within_3", 32'((lat >= 1) && (lat <= 3)), 1);
      wait_locked("relock_after_loss");

      // relock_req while running.
      cycle(1'b1, 1'b1, 1'b0);
      check_val("relock_run_state", 32'(state_o), S_PLLRST);
      check_val("relock_run_rst_out", 32'(rst_out), 3'b111);

      // Glitchy lock: 6 high / 2 low bursts never qualify.
      bad = 0;
      for (int r = 0; r < 4; r++)
         for (int i = 0; i < 8; i++) begin
            cycle(i < 6, 1'b0, 1'b0);
            if (rst_out != 3'b111) bad++;
         end
      check_val("glitch_hold", bad, 0);
      trel = -1;
      for (int i = 0; i < 100 && trel < 0; i++) begin
         cycle(1'b1, 1'b0, 1'b0);
         if (rst_out != 3'b111) trel = i;
      end
      check_val("glitch_release_delay", trel, 2 + LOCK_STABLE);
      wait_locked("glitch_locked");

      // Lock never comes: two timeouts lead to FAULT.
      cycle(1'b0, 1'b1, 1'b0);
      tcy = -1;
      for (int i = 0; i < 300 && tcy < 0; i++) begin
         cycle(1'b0, 1'b0, 1'b0);
         if (retry_cnt == 1) tcy = i + 1;
      end
      check_val("timeout_cycles", tcy, PLL_RST_CYCLES + LOCK_TIMEOUT);
      check_val("timeout_pll_reset", 32'(pll_reset), 1);
      for (int i = 0; i < 300 && !fault; i++) cycle(1'b0, 1'b0, 1'b0);
      check_val("fault_flag", 32'(fault), 1);
      check_val("fault_retry", 32'(retry_cnt), MAX_RETRY);
      check_val("fault_pll_reset", 32'(pll_reset), 1);
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0);
      check_val("fault_hold", 32'(state_o), S_FAULT);

      cycle(1'b1, 1'b1, 1'b0);
      check_val("relock_fault_state", 32'(state_o), S_PLLRST);
      check_val("relock_fault_flag", 32'(fault), 0);
      check_val("relock_fault_retry", 32'(retry_cnt), 0);

      // relock_req in the same cycle the FSM sees lock loss.
      wait_locked("coincide_locked");
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      check_val("coincide_state", 32'(state_o), S_PLLRST);
      check_val("coincide_locked_low", 32'(locked), 0);
      check_val("coincide_retry", 32'(retry_cnt), 0);

      // Reset in the middle of RELEASE.
      for (int i = 0; i < 300 && state_o != 3'(S_RELEASE); i++) cycle(1'b1, 1'b0, 1'b0);
      check_val("reach_release", 32'(state_o), S_RELEASE);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1);
      check_reset_values("mid_release_reset");

      // Random lock runs with occasional relock and reset.
      run_left = 0;
      lv = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         if (run_left == 0) begin
            lv       = ($urandom_range(0, 3) != 0);
            run_left = $urandom_range(1, 40);
         end
         run_left--;
         rq = ($urandom_range(0, 199) == 0);
         rs = ($urandom_range(0, 499) == 0);
         cycle(lv, rq, rs);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
